// File: rtl/load_store_ctrl.sv
// rtl/load_store_ctrl.sv - RV32I load/store sequencer for the data-memory port
//
// Accepts one load/store at a time and turns it into one or two word-aligned
// memory beats with byte strobes. Word-crossing accesses are split.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_we, req_funct3, req_addr,  request: store flag, size code, byte address,
//   req_wdata                      right-justified store data
//   rsp_valid, rsp_rdata, rsp_err  one-cycle completion pulse with extended load
//                                  data and illegal-size flag
//   mem_valid/mem_ready            memory beat handshake
//   mem_we, mem_addr, mem_wstrb,   beat command (zero outside beats)
//   mem_wdata
//   mem_rdata                      read word, valid in the handshake cycle
module load_store_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] w0_q, w0_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        req_legal;
    logic [3:0]  size_m;
    logic [7:0]  sm;
    logic        split;
    logic [31:0] beat0_addr;
    logic [31:0] beat1_addr;
    logic [63:0] wdata_dbl;
    logic [31:0] wdata_rot;
    logic [31:0] asm_lo;
    logic [31:0] asm_hi;
    logic [63:0] asm_pair;
    logic [31:0] x;
    logic [31:0] load_data;
    logic        in_beat;

    // Legality is judged on the live request so an illegal code can skip
    // straight to RESP without touching memory.
    always_comb begin
        req_legal = 1'b0;
        if (req_we) begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010);
        end else begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                        (req_funct3 == 3'b101);
        end
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   size_m = 4'b0001;
            2'b01:   size_m = 4'b0011;
            default: size_m = 4'b1111;
        endcase
    end

    // Bytes that spill into sm[7:4] belong to the next word.
    assign sm         = {4'b0000, size_m} << addr_q[1:0];
    assign split      = |sm[7:4];
    assign beat0_addr = {addr_q[31:2], 2'b00};
    assign beat1_addr = beat0_addr + 32'd4;

    // Rotate left by 8*off: same word on both beats, strobes pick the lanes.
    assign wdata_dbl  = {wdata_q, wdata_q} << {addr_q[1:0], 3'b000};
    assign wdata_rot  = wdata_dbl[63:32];

    // The final read beat feeds the extractor directly so the response can be
    // registered on the same edge as the last handshake.
    always_comb begin
        if (state_q == S_BEAT1) begin
            asm_lo = w0_q;
            asm_hi = mem_rdata;
        end else begin
            asm_lo = mem_rdata;
            asm_hi = 32'd0;
        end
    end

    assign asm_pair = {asm_hi, asm_lo} >> {addr_q[1:0], 3'b000};
    assign x        = asm_pair[31:0];

    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{24{x[7]}}, x[7:0]};
            3'b001:  load_data = {{16{x[15]}}, x[15:0]};
            3'b100:  load_data = {24'd0, x[7:0]};
            3'b101:  load_data = {16'd0, x[15:0]};
            default: load_data = x;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        w0_d        = w0_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_legal) begin
                        state_d = S_BEAT0;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            S_BEAT0: begin
                if (mem_ready) begin
                    w0_d = mem_rdata;
                    if (split) begin
                        state_d = S_BEAT1;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = we_q ? 32'd0 : load_data;
                    end
                end
            end
            S_BEAT1: begin
                if (mem_ready) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'd0 : load_data;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            w0_q        <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            w0_q        <= w0_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Beat outputs decode only registered state and latched fields, so they
    // stay stable through wait states and drop with the asynchronous reset.
    assign in_beat   = (state_q == S_BEAT0) || (state_q == S_BEAT1);
    assign req_ready = (state_q == S_IDLE);
    assign mem_valid = in_beat;
    assign mem_we    = in_beat && we_q;
    assign mem_addr  = (state_q == S_BEAT0) ? beat0_addr :
                       (state_q == S_BEAT1) ? beat1_addr : 32'd0;
    assign mem_wstrb = !we_q                 ? 4'd0    :
                       (state_q == S_BEAT0) ? sm[3:0] :
                       (state_q == S_BEAT1) ? sm[7:4] : 4'd0;
    assign mem_wdata = in_beat ? wdata_rot : 32'd0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// tb/tb_load_store_ctrl.sv - self-checking bench for load_store_ctrl
module tb_load_store_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] smem [logic [31:0]];
    logic [7:0]  rmem [logic [31:0]];

    always #5 clk = ~clk;

    load_store_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] wa);
        if (smem.exists(wa)) return smem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] ba);
        logic [31:0] w;
        if (rmem.exists(ba)) return rmem[ba];
        w = init_word({ba[31:2], 2'b00});
        return w[8*ba[1:0] +: 8];
    endfunction

    task automatic preload(input logic [31:0] wa, input logic [31:0] word);
        smem[wa] = word;
        for (int i = 0; i < 4; i++) rmem[wa + i] = word[8*i +: 8];
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int stall, input bit rnd,
                          input bit junk, output logic [31:0] rdata_o);
        bit          legal;
        bit          done;
        int          sz, nb, hs, stalls_seen, lat, left;
        logic [31:0] a [2];
        logic [3:0]  strb [2];
        logic [31:0] wexp, dexp, v, ba, got_d, cur;
        logic        got_e;
        logic [1:0]  off;

        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = addr[1:0];
        a[0]  = {addr[31:2], 2'b00};
        a[1]  = a[0] + 32'd4;
        strb[0] = 4'd0;
        strb[1] = 4'd0;
        nb = 1;
        for (int i = 0; i < sz; i++) begin
            ba = addr + i;
            if ({ba[31:2], 2'b00} == a[0]) strb[0][ba[1:0]] = 1'b1;
            else begin
                strb[1][ba[1:0]] = 1'b1;
                nb = 2;
            end
        end
        if (!legal) nb = 0;
        wexp = 32'd0;
        for (int j = 0; j < 4; j++) wexp[8*((off + j) % 4) +: 8] = wd[8*j +: 8];
        v = 32'd0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_rd(addr + i);
        case (f3)
            3'd0:    dexp = {{24{v[7]}}, v[7:0]};
            3'd1:    dexp = {{16{v[15]}}, v[15:0]};
            3'd4:    dexp = {24'd0, v[7:0]};
            3'd5:    dexp = {16'd0, v[15:0]};
            default: dexp = v;
        endcase
        if (!legal || we) dexp = 32'd0;

        @(negedge clk);
        check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);

        hs = 0; stalls_seen = 0; done = 0; left = stall; lat = 0;
        got_d = 32'hDEAD_BEEF; got_e = 1'bx;
        for (int c = 1; c <= 300 && !done; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (junk) begin
                    req_we     = $urandom_range(0, 1);
                    req_funct3 = $urandom_range(0, 7);
                    req_addr   = $urandom;
                    req_wdata  = $urandom;
                end else req_valid = 1'b0;
            end
            check_eq("req_ready_busy", {31'd0, req_ready}, 32'd0);
            if (mem_valid) begin
                if (hs >= nb) begin
                    check_eq("beat_count_excess", hs + 1, nb);
                    mem_ready = 1'b1;
                end else begin
                    check_eq("beat_addr", mem_addr, a[hs]);
                    check_eq("beat_we", {31'd0, mem_we}, {31'd0, we});
                    check_eq("beat_wstrb", {28'd0, mem_wstrb}, we ? {28'd0, strb[hs]} : 32'd0);
                    if (we) check_eq("beat_wdata", mem_wdata, wexp);
                    if (left > 0) begin
                        left--;
                        mem_ready = 1'b0;
                    end else if (rnd && $urandom_range(0, 2) == 0) mem_ready = 1'b0;
                    else mem_ready = 1'b1;
                    if (!mem_ready) begin
                        stalls_seen++;
                        mem_rdata = $urandom;
                    end else begin
                        if (mem_we) begin
                            cur = slave_rd(mem_addr);
                            for (int k = 0; k < 4; k++)
                                if (mem_wstrb[k]) cur[8*k +: 8] = mem_wdata[8*k +: 8];
                            smem[mem_addr] = cur;
                            mem_rdata = $urandom;
                        end else mem_rdata = slave_rd(mem_addr);
                        hs++;
                    end
                end
            end else begin
                mem_ready = 1'b0;
                check_eq("idle_mem_addr", mem_addr, 32'd0);
                check_eq("idle_mem_wdata", mem_wdata, 32'd0);
                check_eq("idle_mem_we_strb", {27'd0, mem_we, mem_wstrb}, 32'd0);
            end
            if (rsp_valid) begin
                done  = 1;
                lat   = c;
                got_d = rsp_rdata;
                got_e = rsp_err;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        mem_ready = 1'b0;
        check_eq("rsp_seen", {31'd0, done}, 32'd1);
        check_eq("latency", lat, legal ? nb + 1 + stalls_seen : 1);
        if (!rnd && nb > 0) check_eq("stall_cycles", stalls_seen, stall);
        check_eq("beat_count", hs, nb);
        check_eq("rsp_err", {31'd0, got_e}, {31'd0, !legal});
        check_eq("rsp_rdata", got_d, dexp);
        @(negedge clk);
        check_eq("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
        check_eq("rsp_rdata_idle", rsp_rdata, 32'd0);
        check_eq("req_ready_back", {31'd0, req_ready}, 32'd1);
        if (legal && we)
            for (int i = 0; i < sz; i++) rmem[addr + i] = wd[8*i +: 8];
        rdata_o = got_d;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] ra;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;

        @(negedge clk);
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp", {31'd0, rsp_err} | rsp_rdata, 32'd0);
        check_eq("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", {27'd0, mem_we, mem_wstrb} | mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        preload(32'h1000, 32'h80FF1234);
        do_req(1'b0, 3'b000, 32'h1003, 32'h0, 0, 0, 0, r);
        check_eq("lb_sext", r, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h1003, 32'h0, 0, 0, 0, r);
        check_eq("lbu_zext", r, 32'h00000080);
        do_req(1'b0, 3'b001, 32'h1000, 32'h0, 0, 0, 0, r);
        check_eq("lh_low", r, 32'h00001234);

        preload(32'h2000, 32'hAABBCCDD);
        preload(32'h2004, 32'h11223344);
        do_req(1'b0, 3'b010, 32'h2002, 32'h0, 0, 0, 0, r);
        check_eq("lw_split", r, 32'h3344AABB);

        do_req(1'b1, 3'b001, 32'h3003, 32'h0000BEEF, 0, 0, 0, r);
        check_eq("sh_split_rdata", r, 32'h0);
        do_req(1'b0, 3'b101, 32'h3003, 32'h0, 0, 0, 0, r);
        check_eq("sh_split_readback", r, 32'h0000BEEF);
        do_req(1'b1, 3'b010, 32'h3008, 32'hCAFEF00D, 0, 0, 0, r);
        do_req(1'b1, 3'b000, 32'h3009, 32'h000000A5, 0, 0, 0, r);
        do_req(1'b0, 3'b010, 32'h3008, 32'h0, 0, 0, 0, r);
        check_eq("sb_merge", r, 32'hCAFEA50D);

        do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, 0, 0, r);
        do_req(1'b0, 3'b010, 32'h2000, 32'h0, 5, 0, 1, r);
        check_eq("lw_stalled", r, 32'hAABBCCDD);
        do_req(1'b0, 3'b010, 32'h2003, 32'h0, 3, 0, 1, r);

        do_req(1'b0, 3'b011, 32'h1000, 32'h0, 0, 0, 0, r);
        do_req(1'b1, 3'b100, 32'h1000, 32'h12345678, 0, 0, 0, r);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h2002;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("rst_test_beat0", {31'd0, mem_valid}, 32'd1);
        mem_ready = 1'b1;
        mem_rdata = slave_rd(mem_addr);
        @(negedge clk);
        check_eq("rst_test_beat1_addr", mem_addr, 32'h2004);
        mem_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_async_mem_valid", {31'd0, mem_valid}, 32'd0);
        check_eq("rst_async_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        rst = 1'b0;
        do_req(1'b0, 3'b000, 32'h1003, 32'h0, 0, 0, 0, r);
        check_eq("post_rst_lb", r, 32'hFFFFFF80);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 2))
                0:       ra = 32'h0000_0100;
                1:       ra = 32'hFFFF_FFF8;
                default: ra = 32'h0000_2000;
            endcase
            ra = ra + $urandom_range(0, 11);
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
                   0, 1, 1'($urandom_range(0, 1)), r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_ctrl.md
# load_store_ctrl

Sequencing controller for the data-memory port of the single-cycle core. It accepts one load/store request at a time from the execute stage. It converts the RV32I size/sign code (funct3) and the byte address into one or two word-aligned memory beats with byte strobes, and returns the extracted, extended load data. It also stalls the core through `req_ready`. Accesses that are misaligned and cross a word boundary are split into two beats.

## Interface
- No parameters. Address and data are fixed at 32 bits. The memory word is 4 bytes, little-endian.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: the request fields are valid.
- `req_ready` out 1: the controller can accept a request. High only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: size code. 000 = b, 001 = h, 010 = w, 100 = bu, 101 = hu.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: one-cycle completion pulse. There is no backpressure.
- `rsp_rdata` out 32: extended load data. It is 0 for stores and errors.
- `rsp_err` out 1: illegal funct3. Valid with `rsp_valid`.
- `mem_valid` out 1: memory beat request.
- `mem_ready` in 1: the beat completes in the cycle where `mem_valid` and `mem_ready` are both high. Read data is valid in that same cycle.
- `mem_we` out 1: beat is a write.
- `mem_addr` out 32: word-aligned beat address. `[1:0]` = 00.
- `mem_wstrb` out 4: byte-write strobes. 0 on reads.
- `mem_wdata` out 32: beat write data.
- `mem_rdata` in 32: read word.

## Operation
- **States:** IDLE, BEAT0, BEAT1, RESP.
- **Accept:** a request is accepted when `req_valid` and `req_ready` are both high. The controller latches `we`, `funct3`, `addr`, and `wdata`.
- **Legality:**
  - Loads accept funct3 000, 001, 010, 100, 101.
  - Stores accept funct3 000, 001, 010.
  - Any other code goes IDLE -> RESP with `rsp_err` = 1 and `rsp_rdata` = 0. No memory beat is issued.
- **Masks and offsets:**
  - `off = addr[1:0]`.
  - Size mask `m` is 0001 for b/bu, 0011 for h/hu, and 1111 for w.
  - `sm = {4'b0, m} << off`, an 8-bit value.
  - `split = |sm[7:4]`.
- **Beat addresses:**
  - BEAT0: `mem_addr = {addr[31:2], 2'b00}`, `mem_wstrb = we ? sm[3:0] : 0`.
  - BEAT1: `mem_addr` = beat0 address + 4, modulo 2^32. 0xFFFFFFFC wraps to 0x00000000. `mem_wstrb = we ? sm[7:4] : 0`.
- **Store data:** on both beats, `mem_wdata = wdata` rotated left by `8*off`.
- **Transitions:**
  - BEAT0 with handshake: go to BEAT1 if `split`, otherwise go to RESP.
  - BEAT1 with handshake: go to RESP.
  - RESP: go to IDLE unconditionally.
- **Load assembly:**
  - Capture `mem_rdata` on each read handshake into `w0` and `w1`. `w1` = 0 when there is no split.
  - `x = ({w1, w0} >> 8*off)[31:0]`.
  - b: sign-extend `x[7:0]`. h: sign-extend `x[15:0]`. w: `x`. bu: zero-extend `x[7:0]`. hu: zero-extend `x[15:0]`.
- **Response:** `rsp_rdata` and `rsp_err` are registered, valid only while `rsp_valid` = 1, and 0 otherwise.
- **During a beat:**
  - `mem_valid` = 1 in BEAT0 and BEAT1 only.
  - `mem_we`, `mem_addr`, `mem_wstrb`, and `mem_wdata` hold stable while `mem_valid` is high and `mem_ready` is low.
  - `mem_we`, `mem_addr`, `mem_wstrb`, and `mem_wdata` are 0 outside beats.
- **Request input outside IDLE:** `req_valid` is ignored.

## Timing
- **Reset values:** state IDLE. `req_ready` = 1. All other outputs are 0.
- **During `rst`:** requests are ignored, even though `req_ready` reads 1.
- **Latency** (accept at cycle T, `mem_ready` tied high):
  - Illegal request: `rsp_valid` at T+1.
  - Single beat: `mem_valid` at T+1, `rsp_valid` at T+2.
  - Split: beats at T+1 and T+2, `rsp_valid` at T+3.
- **Wait states:** each cycle with `mem_ready` low adds one cycle to the latency above.
- **Back-to-back requests:** `req_ready` returns to 1 the cycle after RESP. The next request is accepted at the earliest at T+3 (single beat).
- **Reset mid-operation:**
  - All state returns to IDLE asynchronously and `mem_valid` drops immediately.
  - No response is issued.
  - A completed store beat0 is not rolled back.

## Test plan
- **Sign and zero extension:** word 0x80FF1234 at 0x1000. lb @0x1003 -> one beat at addr 0x1000, `rsp_rdata` 0xFFFFFF80. lbu @0x1003 -> 0x00000080. lh @0x1000 -> 0x00001234.
- **Split load:** 0x2000 = 0xAABBCCDD, 0x2004 = 0x11223344. lw @0x2002 -> beats at 0x2000 then 0x2004, `rsp_rdata` 0x3344AABB at T+3.
- **Split store:** sh @0x3003, wdata 0x0000BEEF -> beat0 addr 0x3000, wstrb 1000, wdata 0xEF0000BE. Beat1 addr 0x3004, wstrb 0001, same wdata. Response has `rsp_rdata` = 0.
- **Wrap-around:** lw @0xFFFFFFFE -> beat1 `mem_addr` 0x00000000.
- **Memory stall:** `mem_ready` low for 5 cycles -> `mem_*` stable, `req_ready` = 0, a concurrent `req_valid` is ignored, and `rsp_valid` arrives 5 cycles late.
- **Illegal code:** load with funct3 011, or store with funct3 100 -> no `mem_valid`, `rsp_valid` and `rsp_err` = 1 at T+1.
- **Reset mid-operation:** assert `rst` during BEAT1 -> `mem_valid` = 0 in the same cycle, no `rsp_valid`, and a fresh request is accepted after `rst` is released.
